// File: rtl/target_entry_collector_pkg.sv
// Shared scan-code constants, digit lookup table and controller state type
// for the target entry collector.
package target_entry_collector_pkg;

   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_ENTER = 8'h5A;
   localparam logic [7:0] SC_BKSP  = 8'h66;
   localparam logic [7:0] SC_ESC   = 8'h76;

   // Entry n holds the make code of digit n.
   localparam logic [9:0][7:0] DIGIT_SC = {
      8'h46, 8'h3E, 8'h3D, 8'h36, 8'h2E, 8'h25, 8'h26, 8'h1E, 8'h16, 8'h45
   };

   localparam int NUM_DIGITS = 8;

   typedef enum logic [2:0] {
      IDLE,
      QUEUE,
      START,
      WAIT_LO,
      WAIT_HI
   } state_t;

endpackage

// File: rtl/target_entry_collector_ps2_digit_decoder.sv
// Combinational classifier for a single PS/2 set-2 make code: digit value,
// Enter, Backspace or Esc.
module target_entry_collector_ps2_digit_decoder
   import target_entry_collector_pkg::*;
(
   input  logic [7:0] code,
   output logic       is_digit,
   output logic [3:0] digit,
   output logic       is_enter,
   output logic       is_bksp,
   output logic       is_esc
);

   always_comb begin
      is_digit = 1'b0;
      digit    = 4'd0;
      for (int i = 0; i < 10; i++) begin
         if (code == DIGIT_SC[i]) begin
            is_digit = 1'b1;
            digit    = 4'(i);
         end
      end
   end

   assign is_enter = (code == SC_ENTER);
   assign is_bksp  = (code == SC_BKSP);
   assign is_esc   = (code == SC_ESC);

endmodule

// File: rtl/target_entry_collector.sv
// Collects an 8-digit X/Y target entry from PS/2 scan codes and sequences
// commit (queue) and refresh (start) requests toward the target-list printer.
module target_entry_collector
   import target_entry_collector_pkg::*;
#(
   parameter int QUEUE_HOLD     = 2,
   parameter int FINISH_TIMEOUT = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [7:0]  ps2_byte,
   input  logic        ps2_valid,
   input  logic        finish,
   output logic [32:0] targetx,
   output logic [32:0] targety,
   output logic        queue,
   output logic        start,
   output logic [3:0]  entry_pos,
   output logic        busy
);
   // state   | meaning
   // IDLE    | editing; waits for Enter on a full entry or a pending refresh
   // QUEUE   | queue held high so the printer latches the preview slot
   // START   | one-cycle print request
   // WAIT_LO | waiting for the printer to leave idle (bounded)
   // WAIT_HI | waiting for the print loop to finish

   localparam int CNT_MAX = (QUEUE_HOLD > FINISH_TIMEOUT) ? QUEUE_HOLD : FINISH_TIMEOUT;
   localparam int CW      = $clog2(CNT_MAX + 1);

   state_t            state, state_nxt;
   logic [CW-1:0]     cnt, cnt_nxt;
   logic [7:0][3:0]   dig;
   logic [3:0]        pos;
   logic              pend, brk, ext, clear_after;
   logic              queue_nxt, start_nxt, pend_clr, commit_done, wrap_clear;

   logic              dec_is_digit, dec_is_enter, dec_is_bksp, dec_is_esc;
   logic [3:0]        dec_digit;
   logic              byte_make, key_enter, edit_ok;
   logic              acc_digit, acc_bksp, acc_esc, edit;

   target_entry_collector_ps2_digit_decoder u_ps2_digit_decoder (
      .code     (ps2_byte),
      .is_digit (dec_is_digit),
      .digit    (dec_digit),
      .is_enter (dec_is_enter),
      .is_bksp  (dec_is_bksp),
      .is_esc   (dec_is_esc)
   );

   // Prefix bytes and the byte following a break never count as key presses.
   assign byte_make = ps2_valid && !brk && (ps2_byte != SC_BREAK) && (ps2_byte != SC_EXT);
   assign key_enter = byte_make && dec_is_enter;
   assign edit_ok   = (state != QUEUE);
   assign acc_digit = byte_make && !ext && dec_is_digit && edit_ok && (pos != 4'(NUM_DIGITS));
   assign acc_bksp  = byte_make && !ext && dec_is_bksp && edit_ok && (pos != 4'd0);
   assign acc_esc   = byte_make && !ext && dec_is_esc && edit_ok;
   assign edit      = acc_digit || acc_bksp || acc_esc;

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      pend_clr    = 1'b0;
      commit_done = 1'b0;
      wrap_clear  = 1'b0;
      case (state)
         IDLE: begin
            if (key_enter && (pos == 4'(NUM_DIGITS))) begin
               state_nxt = QUEUE;
               cnt_nxt   = CW'(QUEUE_HOLD - 1);
            end else if (pend && !ps2_valid) begin
               state_nxt = START;
            end
         end
         QUEUE: begin
            if (cnt == '0) begin
               state_nxt   = START;
               commit_done = 1'b1;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         START: begin
            state_nxt = WAIT_LO;
            cnt_nxt   = CW'(FINISH_TIMEOUT - 1);
            pend_clr  = 1'b1;
         end
         WAIT_LO: begin
            if (!finish) begin
               state_nxt = WAIT_HI;
            end else if (cnt == '0) begin
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         WAIT_HI: begin
            if (finish) begin
               state_nxt  = IDLE;
               wrap_clear = clear_after;
            end
         end
         default: state_nxt = IDLE;
      endcase
      queue_nxt = (state_nxt == QUEUE);
      start_nxt = (state_nxt == START);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         queue <= 1'b0;
         start <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         queue <= queue_nxt;
         start <= start_nxt;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         dig         <= '0;
         pos         <= 4'd0;
         pend        <= 1'b0;
         brk         <= 1'b0;
         ext         <= 1'b0;
         clear_after <= 1'b0;
      end else begin
         if (ps2_valid) begin
            if (brk) begin
               brk <= 1'b0;
               ext <= 1'b0;
            end else if (ps2_byte == SC_BREAK) begin
               brk <= 1'b1;
               ext <= 1'b0;
            end else if (ps2_byte == SC_EXT) begin
               ext <= 1'b1;
            end else begin
               ext <= 1'b0;
            end
         end

         if (acc_digit) begin
            dig[pos[2:0]] <= dec_digit;
            pos           <= pos + 4'd1;
         end else if (acc_bksp) begin
            dig[pos[2:0] - 3'd1] <= 4'd0;
            pos                  <= pos - 4'd1;
         end else if (acc_esc) begin
            dig <= '0;
            pos <= 4'd0;
         end

         if (edit || commit_done || wrap_clear) begin
            pend <= 1'b1;
         end else if (pend_clr) begin
            pend <= 1'b0;
         end

         if (commit_done) begin
            clear_after <= 1'b1;
         end else if (wrap_clear) begin
            clear_after <= 1'b0;
         end

         // The post-commit wipe overrides any edit landing in the same cycle.
         if (wrap_clear) begin
            dig <= '0;
            pos <= 4'd0;
         end
      end
   end

   always_comb begin
      targetx = '0;
      targety = '0;
      for (int i = 0; i < 4; i++) begin
         targetx[8*(3-i) +: 4] = dig[i];
         targety[8*(3-i) +: 4] = dig[i+4];
      end
   end

   assign entry_pos = pos;
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_target_entry_collector.sv
// Self-checking bench for target_entry_collector: directed scenarios plus a
// randomized key stream checked against a digit-list model of the entry.
module tb_target_entry_collector;

   logic        clock;
   logic        reset;
   logic [7:0]  ps2_byte;
   logic        ps2_valid;
   logic        finish;
   logic [32:0] targetx;
   logic [32:0] targety;
   logic        queue;
   logic        start;
   logic [3:0]  entry_pos;
   logic        busy;

   target_entry_collector #(.QUEUE_HOLD(2), .FINISH_TIMEOUT(4)) dut (
      .clock     (clock),
      .reset     (reset),
      .ps2_byte  (ps2_byte),
      .ps2_valid (ps2_valid),
      .finish    (finish),
      .targetx   (targetx),
      .targety   (targety),
      .queue     (queue),
      .start     (start),
      .entry_pos (entry_pos),
      .busy      (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Make codes of digits 0..9.
   logic [7:0] dsc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

   int digs[$];

   function automatic longint model_word(input int base);
      longint v = 0;
      for (int i = 0; i < 4; i++)
         if (base + i < digs.size()) v += longint'(digs[base + i]) << (8 * (3 - i));
      return v;
   endfunction

   task automatic check_model(input string tag);
      check_eq({tag, "_x"}, targetx, model_word(0));
      check_eq({tag, "_y"}, targety, model_word(4));
      check_eq({tag, "_pos"}, entry_pos, digs.size());
   endtask

   // Monitor: pulse counters, longest queue run, length of last busy run.
   int start_cnt = 0, queue_cnt = 0, queue_run = 0, queue_max = 0, busy_run = 0, last_busy_run = 0;
   always @(negedge clock) begin
      if (start) start_cnt++;
      if (queue) begin
         queue_cnt++;
         queue_run++;
         if (queue_run > queue_max) queue_max = queue_run;
      end else begin
         queue_run = 0;
      end
      if (busy) busy_run++;
      else if (busy_run != 0) begin
         last_busy_run = busy_run;
         busy_run = 0;
      end
      if (start || queue) check_eq("start_queue_exclusive", start & queue, 0);
   end

   // Printer model: auto mode drops finish 1 cycle after start, raises it 32 later.
   bit pr_auto = 1'b0;
   initial begin
      finish = 1'b1;
      forever begin
         @(negedge clock);
         if (start && pr_auto) begin
            @(posedge clock); #1;
            finish = 1'b0;
            repeat (32) @(posedge clock);
            #1;
            finish = 1'b1;
         end
      end
   end

   task automatic tick();
      @(posedge clock); #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      ps2_byte  = b;
      ps2_valid = 1'b1;
      tick();
      ps2_valid = 1'b0;
   endtask

   task automatic type_digit(input int d);
      send_byte(dsc[d]);
      if (digs.size() < 8) digs.push_back(d);
   endtask

   task automatic wait_quiet(input string tag);
      int idle_run = 0;
      int n = 0;
      while (idle_run < 4 && n < 500) begin
         tick();
         n++;
         idle_run = busy ? 0 : idle_run + 1;
      end
      check_eq({tag, "_quiet"}, idle_run >= 4, 1);
   endtask

   function automatic bit is_known(input logic [7:0] b);
      for (int i = 0; i < 10; i++) if (b == dsc[i]) return 1'b1;
      return (b == 8'h5A) || (b == 8'h66) || (b == 8'h76) || (b == 8'hF0) || (b == 8'hE0);
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b;
      int n;
      reset     = 1'b1;
      ps2_byte  = 8'h00;
      ps2_valid = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      check_eq("rst_x", targetx, 0);
      check_eq("rst_y", targety, 0);
      check_eq("rst_queue", queue, 0);
      check_eq("rst_start", start, 0);
      check_eq("rst_pos", entry_pos, 0);
      check_eq("rst_busy", busy, 0);

      // Full entry typed back-to-back, one refresh afterwards.
      pr_auto = 1'b1;
      start_cnt = 0;
      for (int d = 1; d <= 8; d++) type_digit(d);
      check_eq("full_x", targetx, 33'h0_0102_0304);
      check_eq("full_y", targety, 33'h0_0506_0708);
      check_eq("full_pos", entry_pos, 8);
      wait_quiet("full");
      check_eq("full_starts", start_cnt, 1);

      // Commit: queue held 2 cycles, print, then wipe and second print.
      start_cnt = 0; queue_max = 0;
      send_byte(8'h5A);
      wait_quiet("commit");
      digs.delete();
      check_eq("commit_qlen", queue_max, 2);
      check_eq("commit_starts", start_cnt, 2);
      check_model("commit");

      // Backspace behaviour.
      type_digit(9); type_digit(9);
      send_byte(8'h66); void'(digs.pop_back());
      check_eq("bksp_x", targetx, 33'h0_0900_0000);
      check_eq("bksp_pos", entry_pos, 1);
      wait_quiet("bksp");
      send_byte(8'h66); void'(digs.pop_back());
      check_model("bksp_to0");
      wait_quiet("bksp_to0");
      start_cnt = 0;
      send_byte(8'h66);
      check_model("bksp_at0");
      wait_quiet("bksp_at0");
      check_eq("bksp_at0_starts", start_cnt, 0);

      // Break and extended codes are ignored.
      type_digit(7);
      wait_quiet("pre_brk");
      start_cnt = 0;
      send_byte(8'hF0); send_byte(8'h16);
      send_byte(8'hE0); send_byte(8'h16);
      check_model("brk_ext");
      wait_quiet("brk_ext");
      check_eq("brk_ext_starts", start_cnt, 0);

      // Enter with a partial entry is ignored.
      for (int d = 0; d < 4; d++) type_digit(d);
      wait_quiet("pos5");
      queue_cnt = 0;
      send_byte(8'h5A);
      wait_quiet("enter_pos5");
      check_eq("enter_pos5_queue", queue_cnt, 0);
      check_model("enter_pos5");

      // Extended Enter commits a full entry.
      for (int d = 4; d < 7; d++) type_digit(d);
      wait_quiet("pos8");
      queue_max = 0;
      send_byte(8'hE0); send_byte(8'h5A);
      wait_quiet("ext_enter");
      digs.delete();
      check_eq("ext_enter_qlen", queue_max, 2);
      check_model("ext_enter");

      // Digit typed while the printer is running yields one follow-up print.
      start_cnt = 0;
      type_digit(3);
      n = 0;
      while (!start && n < 50) begin tick(); n++; end
      check_eq("waithi_start_seen", start, 1);
      repeat (10) tick();
      check_eq("waithi_busy", busy, 1);
      type_digit(4);
      wait_quiet("waithi");
      check_eq("waithi_starts", start_cnt, 2);
      check_model("waithi");

      // Printer never drops finish: START plus FINISH_TIMEOUT cycles busy.
      pr_auto = 1'b0;
      type_digit(5);
      wait_quiet("timeout");
      check_eq("timeout_busy_len", last_busy_run, 5);

      // Reset during QUEUE.
      pr_auto = 1'b1;
      send_byte(8'h76); digs.delete();
      for (int d = 0; d < 8; d++) type_digit(9 - d);
      wait_quiet("pre_rst");
      send_byte(8'h5A);
      n = 0;
      while (!queue && n < 10) begin tick(); n++; end
      check_eq("rstq_queue_seen", queue, 1);
      reset = 1'b1;
      tick();
      digs.delete();
      check_eq("rstq_queue", queue, 0);
      check_eq("rstq_start", start, 0);
      check_eq("rstq_busy", busy, 0);
      check_model("rstq");
      reset = 1'b0;
      tick();

      // Randomized key stream (no Enter) against the digit-list model.
      for (int a = 0; a < 200; a++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4: type_digit($urandom_range(0, 9));
            5: begin
               send_byte(8'h66);
               if (digs.size() > 0) void'(digs.pop_back());
            end
            6: begin
               send_byte(8'h76);
               digs.delete();
            end
            7: begin
               send_byte(8'hF0);
               send_byte(8'($urandom_range(0, 255)));
            end
            8: begin
               do b = 8'($urandom_range(0, 255)); while (b == 8'h5A || b == 8'hE0 || b == 8'hF0);
               send_byte(8'hE0);
               send_byte(b);
            end
            default: begin
               do b = 8'($urandom_range(0, 255)); while (is_known(b));
               send_byte(b);
            end
         endcase
         check_model("rand");
         repeat ($urandom_range(0, 3)) tick();
      end
      wait_quiet("rand_end");
      check_model("rand_end");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
